bcd_mod_counter: RTL and testbench
==================================

// Module: bcd_mod_counter
// PURPOSE
//   Generic two-digit BCD modulo counter: the building block for every clock field (seconds, minutes, hours, 12h/24h).
//   Counts up or down on qualified ticks and emits single-cycle carry/borrow pulses, so stages chain by wiring
//   carry_out to the next stage's count_in. Also supports time-set load and manual adjust without carry.
//   Sits between the 1 Hz enable generator and the display decoders.
// PARAMETERS
//   MODULUS    60  number of states in the count range (2..100)
//   MIN_VALUE  0   lowest count value; range is MIN_VALUE..MIN_VALUE+MODULUS-1 (max value <= 99)
//   MSD_WIDTH  3   width of bcd_msd (3 for max <= 79, 4 otherwise)
// PORTS
//   clock      in   1          system clock, all logic on rising edge
//   reset      in   1          synchronous, active-high
//   enable     in   1          tick qualifier (1 Hz enable); count_in is ignored when low
//   count_in   in   1          count request (carry from lower stage, or 1 for the first stage)
//   count_dir  in   1          0 = count up, 1 = count down
//   adj_up     in   1          manual +1 (wraps, no carry/borrow), not gated by enable
//   adj_down   in   1          manual -1 (wraps, no carry/borrow), not gated by enable
//   load       in   1          synchronous load of load_msd:load_lsd
//   load_lsd   in   4          BCD units digit to load
//   load_msd   in   MSD_WIDTH  BCD tens digit to load
//   bcd_lsd    out  4          current units digit
//   bcd_msd    out  MSD_WIDTH  current tens digit
//   carry_out  out  1          1-cycle pulse: up-count wrapped max -> MIN_VALUE
//   borrow_out out  1          1-cycle pulse: down-count wrapped MIN_VALUE -> max
//   at_max     out  1          combinational: value == max
//   load_err   out  1          1-cycle pulse: rejected load
// BEHAVIOUR
//   - All outputs registered except at_max. Reset: bcd_msd:bcd_lsd = BCD(MIN_VALUE); carry_out, borrow_out, load_err = 0.
//   - Reset mid-operation overrides all inputs; pulses in flight are cleared that cycle.
//   - Priority per cycle: reset > load > adjust > count. Only one value update per cycle.
//   - Count event = enable & count_in & !load & !adj_up & !adj_down. Latency 1 clock: value updates on the next edge.
//   - Up: lsd 9 -> 0 with msd+1; at max -> BCD(MIN_VALUE) and carry_out=1 on the same edge as the wrap.
//   - Down: lsd 0 -> 9 with msd-1; at MIN_VALUE -> max and borrow_out=1 on the same edge.
//   - carry_out/borrow_out are high for exactly one clock per wrap; never sticky; 0 on every non-wrap cycle.
//   - Adjust: adj_up xor adj_down steps the value +/-1 with the same wrap rules, but carry/borrow stay 0.
//     adj_up & adj_down together = no change.
//   - Load valid iff load_lsd <= 9, load_msd <= 9, and MIN_VALUE <= value <= max.
//     Valid: value takes the load on the next edge, no pulses.
//     Invalid: value unchanged, load_err = 1 for one cycle.
//   - Digits never leave the legal range; the counter must not hold a non-BCD or out-of-range value at any time.
//   - Arithmetic is per digit in BCD (no binary-to-BCD conversion of the value); lsd and msd update in the same cycle.
// TESTING
//   1. Default params, value 58, enable=count_in=1 for 2 cycles -> 59, then 00 with carry_out=1 for exactly 1 cycle.
//   2. Value 09, one up tick -> 10, carry_out=0; value 10, one down tick -> 09.
//   3. Value 00, count_dir=1, one tick -> 59, borrow_out=1 for 1 cycle.
//   4. MODULUS=12, MIN_VALUE=1, MSD_WIDTH=1: value 12, up tick -> 01 with carry_out; reset -> 01.
//   5. Load 75 (and load lsd=A) -> value unchanged, load_err=1 for 1 cycle; load 42 -> 42, load_err=0.
//   6. Value 59, adj_up -> 00, carry_out=0. Load + count_in same cycle -> load wins.
//      Reset asserted during a wrap cycle -> 00, all pulses 0.

Source files
------------

// File: rtl/bcd_mod_counter_if.sv
// Signal bundle for one BCD counter stage: count/adjust/load controls in, digits and pulses out.
// The master drives requests and the stage (slave) drives its digits and status back.
interface bcd_mod_counter_if #(
  parameter int MSD_WIDTH = 3
);
  logic                 enable;
  logic                 count_in;
  logic                 count_dir;
  logic                 adj_up;
  logic                 adj_down;
  logic                 load;
  logic [3:0]           load_lsd;
  logic [MSD_WIDTH-1:0] load_msd;
  logic [3:0]           bcd_lsd;
  logic [MSD_WIDTH-1:0] bcd_msd;
  logic                 carry_out;
  logic                 borrow_out;
  logic                 at_max;
  logic                 load_err;

  modport master (
    output enable, count_in, count_dir, adj_up, adj_down, load, load_lsd, load_msd,
    input  bcd_lsd, bcd_msd, carry_out, borrow_out, at_max, load_err
  );

  modport slave (
    input  enable, count_in, count_dir, adj_up, adj_down, load, load_lsd, load_msd,
    output bcd_lsd, bcd_msd, carry_out, borrow_out, at_max, load_err
  );
endinterface

// File: rtl/bcd_mod_counter.sv
// Two-digit BCD modulo counter stage with carry/borrow chaining, manual adjust and checked load.
// Digits are stepped directly in BCD; tens digit is held in MSD_WIDTH bits, arithmetic done at 4 bits.
module bcd_mod_counter #(
  parameter int MODULUS   = 60,
  parameter int MIN_VALUE = 0,
  parameter int MSD_WIDTH = 3
) (
  input  logic               clock,
  input  logic               reset,
  bcd_mod_counter_if.slave   bus
);

  localparam int         MAX_VALUE = MIN_VALUE + MODULUS - 1;
  localparam logic [3:0] MIN_LSD   = 4'(MIN_VALUE % 10);
  localparam logic [3:0] MIN_MSD   = 4'(MIN_VALUE / 10);
  localparam logic [3:0] MAX_LSD   = 4'(MAX_VALUE % 10);
  localparam logic [3:0] MAX_MSD   = 4'(MAX_VALUE / 10);

  logic [3:0]           r_lsd;
  logic [MSD_WIDTH-1:0] r_msd;
  logic                 r_carry;
  logic                 r_borrow;
  logic                 r_load_err;

  logic [3:0] w_msd;
  logic [3:0] w_load_msd;
  logic       w_at_max;
  logic       w_at_min;
  logic       w_load_ok;
  logic [3:0] w_up_lsd, w_up_msd, w_dn_lsd, w_dn_msd;
  logic [3:0] w_lsd_next, w_msd_next;
  logic       w_carry_next, w_borrow_next, w_load_err_next;

  // Lexicographic digit compare keeps range checks in BCD without converting to binary.
  function automatic logic in_range(input logic [3:0] msd, input logic [3:0] lsd);
    logic ge_min;
    logic le_max;
    ge_min = (msd > MIN_MSD) || ((msd == MIN_MSD) && (lsd >= MIN_LSD));
    le_max = (msd < MAX_MSD) || ((msd == MAX_MSD) && (lsd <= MAX_LSD));
    return ge_min && le_max;
  endfunction

  assign w_msd      = 4'(r_msd);
  assign w_load_msd = 4'(bus.load_msd);
  assign w_at_max   = (w_msd == MAX_MSD) && (r_lsd == MAX_LSD);
  assign w_at_min   = (w_msd == MIN_MSD) && (r_lsd == MIN_LSD);
  assign w_load_ok  = (bus.load_lsd <= 4'd9) && (w_load_msd <= 4'd9)
                      && in_range(w_load_msd, bus.load_lsd);

  always_comb begin
    w_up_lsd = r_lsd + 4'd1;
    w_up_msd = w_msd;
    if (w_at_max) begin
      w_up_lsd = MIN_LSD;
      w_up_msd = MIN_MSD;
    end else if (r_lsd == 4'd9) begin
      w_up_lsd = 4'd0;
      w_up_msd = w_msd + 4'd1;
    end

    w_dn_lsd = r_lsd - 4'd1;
    w_dn_msd = w_msd;
    if (w_at_min) begin
      w_dn_lsd = MAX_LSD;
      w_dn_msd = MAX_MSD;
    end else if (r_lsd == 4'd0) begin
      w_dn_lsd = 4'd9;
      w_dn_msd = w_msd - 4'd1;
    end
  end

  // One value update per cycle: load beats adjust beats count.
  always_comb begin
    w_lsd_next      = r_lsd;
    w_msd_next      = w_msd;
    w_carry_next    = 1'b0;
    w_borrow_next   = 1'b0;
    w_load_err_next = 1'b0;
    if (bus.load) begin
      if (w_load_ok) begin
        w_lsd_next = bus.load_lsd;
        w_msd_next = w_load_msd;
      end else begin
        w_load_err_next = 1'b1;
      end
    end else if (bus.adj_up || bus.adj_down) begin
      if (bus.adj_up && !bus.adj_down) begin
        w_lsd_next = w_up_lsd;
        w_msd_next = w_up_msd;
      end else if (bus.adj_down && !bus.adj_up) begin
        w_lsd_next = w_dn_lsd;
        w_msd_next = w_dn_msd;
      end
    end else if (bus.enable && bus.count_in) begin
      if (bus.count_dir) begin
        w_lsd_next    = w_dn_lsd;
        w_msd_next    = w_dn_msd;
        w_borrow_next = w_at_min;
      end else begin
        w_lsd_next   = w_up_lsd;
        w_msd_next   = w_up_msd;
        w_carry_next = w_at_max;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_lsd      <= MIN_LSD;
      r_msd      <= MIN_MSD[MSD_WIDTH-1:0];
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_load_err <= 1'b0;
    end else begin
      r_lsd      <= w_lsd_next;
      r_msd      <= w_msd_next[MSD_WIDTH-1:0];
      r_carry    <= w_carry_next;
      r_borrow   <= w_borrow_next;
      r_load_err <= w_load_err_next;
    end
  end

  assign bus.bcd_lsd    = r_lsd;
  assign bus.bcd_msd    = r_msd;
  assign bus.carry_out  = r_carry;
  assign bus.borrow_out = r_borrow;
  assign bus.load_err   = r_load_err;
  assign bus.at_max     = w_at_max;

endmodule

// File: tb/tb_bcd_mod_counter.sv
// Drives a 00..59 stage and a 01..12 stage with the same controls and checks both
// against an integer-valued reference model, with directed scenarios followed by random traffic.
module tb_bcd_mod_counter;

  logic clock;
  logic reset;

  bcd_mod_counter_if #(.MSD_WIDTH(3)) if0 ();
  bcd_mod_counter_if #(.MSD_WIDTH(1)) if1 ();

  bcd_mod_counter #(.MODULUS(60), .MIN_VALUE(0), .MSD_WIDTH(3)) dut0 (
    .clock (clock),
    .reset (reset),
    .bus   (if0)
  );

  bcd_mod_counter #(.MODULUS(12), .MIN_VALUE(1), .MSD_WIDTH(1)) dut1 (
    .clock (clock),
    .reset (reset),
    .bus   (if1)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;
  int v0 = 0;
  int v1 = 1;

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: value is a plain integer in [minv, maxv], stepped with modular arithmetic.
  task automatic model_step(inout int v, input int minv, input int maxv,
                            input bit rst, input bit en, input bit ci, input bit dir,
                            input bit au, input bit ad, input bit ld, input int ll, input int lm,
                            output bit c, output bit b, output bit e);
    int val;
    c = 1'b0;
    b = 1'b0;
    e = 1'b0;
    val = lm * 10 + ll;
    if (rst) begin
      v = minv;
    end else if (ld) begin
      if (ll <= 9 && lm <= 9 && val >= minv && val <= maxv) v = val;
      else e = 1'b1;
    end else if (au || ad) begin
      if (au && !ad) v = (v == maxv) ? minv : v + 1;
      else if (ad && !au) v = (v == minv) ? maxv : v - 1;
    end else if (en && ci) begin
      if (!dir) begin
        c = (v == maxv);
        v = (v == maxv) ? minv : v + 1;
      end else begin
        b = (v == minv);
        v = (v == minv) ? maxv : v - 1;
      end
    end
  endtask

  function automatic int val0();
    return int'(if0.bcd_msd) * 10 + int'(if0.bcd_lsd);
  endfunction

  function automatic int val1();
    return int'(if1.bcd_msd) * 10 + int'(if1.bcd_lsd);
  endfunction

  task automatic tick(input bit rst, input bit en, input bit ci, input bit dir,
                      input bit au, input bit ad, input bit ld,
                      input bit [3:0] ll, input bit [3:0] lm);
    bit c0, b0, e0, c1, b1, e1;
    @(negedge clock);
    reset = rst;
    if0.enable = en;  if0.count_in = ci;  if0.count_dir = dir;
    if0.adj_up = au;  if0.adj_down = ad;  if0.load = ld;
    if0.load_lsd = ll; if0.load_msd = lm[2:0];
    if1.enable = en;  if1.count_in = ci;  if1.count_dir = dir;
    if1.adj_up = au;  if1.adj_down = ad;  if1.load = ld;
    if1.load_lsd = ll; if1.load_msd = lm[0];
    model_step(v0, 0, 59, rst, en, ci, dir, au, ad, ld, int'(ll), int'(lm[2:0]), c0, b0, e0);
    model_step(v1, 1, 12, rst, en, ci, dir, au, ad, ld, int'(ll), int'(lm[0]), c1, b1, e1);
    @(posedge clock);
    #1;
    check("m60.lsd",    int'(if0.bcd_lsd),    v0 % 10);
    check("m60.msd",    int'(if0.bcd_msd),    v0 / 10);
    check("m60.carry",  int'(if0.carry_out),  int'(c0));
    check("m60.borrow", int'(if0.borrow_out), int'(b0));
    check("m60.lerr",   int'(if0.load_err),   int'(e0));
    check("m60.atmax",  int'(if0.at_max),     int'(v0 == 59));
    check("m12.lsd",    int'(if1.bcd_lsd),    v1 % 10);
    check("m12.msd",    int'(if1.bcd_msd),    v1 / 10);
    check("m12.carry",  int'(if1.carry_out),  int'(c1));
    check("m12.borrow", int'(if1.borrow_out), int'(b1));
    check("m12.lerr",   int'(if1.load_err),   int'(e1));
    check("m12.atmax",  int'(if1.at_max),     int'(v1 == 12));
    $display("[TB] rst=%0d en=%0d ci=%0d dir=%0d au=%0d ad=%0d ld=%0d ll=%0d lm=%0d -> m60=%0d c=%0d b=%0d e=%0d | m12=%0d c=%0d b=%0d e=%0d",
             rst, en, ci, dir, au, ad, ld, ll, lm, val0(), if0.carry_out, if0.borrow_out,
             if0.load_err, val1(), if1.carry_out, if1.borrow_out, if1.load_err);
  endtask

  initial begin
    reset = 1'b1;
    if0.enable = 0; if0.count_in = 0; if0.count_dir = 0; if0.adj_up = 0; if0.adj_down = 0;
    if0.load = 0; if0.load_lsd = 0; if0.load_msd = 0;
    if1.enable = 0; if1.count_in = 0; if1.count_dir = 0; if1.adj_up = 0; if1.adj_down = 0;
    if1.load = 0; if1.load_lsd = 0; if1.load_msd = 0;

    // Reset state
    tick(1, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    check("rst.m60", val0(), 0);
    check("rst.m12", val1(), 1);

    // 58 -> 59 -> 00 with a single carry pulse
    tick(0, 0, 0, 0, 0, 0, 1, 4'd8, 4'd5);
    tick(0, 1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    check("t1.59", val0(), 59);
    tick(0, 1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    check("t1.wrap", val0(), 0);
    check("t1.carry", int'(if0.carry_out), 1);
    tick(0, 0, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    check("t1.carry_drop", int'(if0.carry_out), 0);

    // Decade crossing both ways
    tick(0, 0, 0, 0, 0, 0, 1, 4'd9, 4'd0);
    tick(0, 1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    check("t2.up10", val0(), 10);
    tick(0, 1, 1, 1, 0, 0, 0, 4'd0, 4'd0);
    check("t2.dn09", val0(), 9);

    // Borrow at minimum
    tick(0, 0, 0, 0, 0, 0, 1, 4'd0, 4'd0);
    tick(0, 1, 1, 1, 0, 0, 0, 4'd0, 4'd0);
    check("t3.borrow_val", val0(), 59);
    check("t3.borrow", int'(if0.borrow_out), 1);

    // 01..12 stage wraps 12 -> 01, then reset returns it to 01
    tick(0, 0, 0, 0, 0, 0, 1, 4'd2, 4'd1);
    tick(0, 1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    check("t4.wrap", val1(), 1);
    check("t4.carry", int'(if1.carry_out), 1);
    tick(0, 1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    tick(1, 0, 0, 0, 0, 0, 0, 4'd0, 4'd0);
    check("t4.rst", val1(), 1);

    // Rejected and accepted loads
    tick(0, 0, 0, 0, 0, 0, 1, 4'd5, 4'd7);
    check("t5.err75", int'(if0.load_err), 1);
    tick(0, 0, 0, 0, 0, 0, 1, 4'hA, 4'd1);
    check("t5.errA", int'(if0.load_err), 1);
    tick(0, 0, 0, 0, 0, 0, 1, 4'd2, 4'd4);
    check("t5.load42", val0(), 42);

    // Adjust wraps silently; load beats count; reset clears a pulse in flight
    tick(0, 0, 0, 0, 0, 0, 1, 4'd9, 4'd5);
    tick(0, 1, 1, 0, 1, 0, 0, 4'd0, 4'd0);
    check("t6.adj_wrap", val0(), 0);
    tick(0, 1, 1, 0, 0, 0, 1, 4'd3, 4'd3);
    check("t6.load_wins", val0(), 33);
    tick(0, 1, 1, 0, 1, 1, 0, 4'd0, 4'd0);
    check("t6.adj_both", val0(), 33);
    tick(0, 0, 0, 0, 0, 0, 1, 4'd9, 4'd5);
    tick(0, 1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    tick(1, 1, 1, 0, 0, 0, 0, 4'd0, 4'd0);
    check("t6.rst_val", val0(), 0);
    check("t6.rst_carry", int'(if0.carry_out), 0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      tick($urandom_range(0, 49) == 0,
           $urandom_range(0, 3) != 0,
           $urandom_range(0, 4) != 0,
           $urandom_range(0, 2) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 7) == 0,
           $urandom_range(0, 9) == 0,
           4'($urandom_range(0, 11)),
           4'($urandom_range(0, 9)));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
